// File: rtl/simon_seq_player.sv
// Simon sequence store: captures RNG symbols, replays them over valid/ready, checks presses.
// Playback valid 1 cycle after start, held until accepted; press results pulse 1 cycle later. Press timeout with `SIMON_SEQ_TIMEOUT_EN.
module simon_seq_player #(
  parameter int MAX_LEN     = 32,
  parameter int SYM_W       = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SYM_W-1:0]             rnd_i,
  input  logic                         append_i,
  input  logic                         clear_i,
  input  logic                         play_start_i,
  output logic [SYM_W-1:0]             play_sym_o,
  output logic                         play_valid_o,
  input  logic                         play_ready_i,
  output logic                         play_done_o,
  input  logic                         chk_start_i,
  input  logic                         press_i,
  input  logic [SYM_W-1:0]             press_sym_i,
  output logic                         match_o,
  output logic                         mismatch_o,
  output logic                         round_ok_o,
  output logic [$clog2(MAX_LEN+1)-1:0] len_o,
  output logic                         full_o,
  output logic                         busy_o,
  output logic                         timeout_o
);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PLAY, DONE, CHECK} state_t;

  state_t           state_q;
  logic [SYM_W-1:0] mem_q [MAX_LEN];
  logic [LW-1:0]    len_q, idx_q;
  logic [SYM_W-1:0] play_sym_q;
  logic             play_valid_q, play_done_q;
  logic             match_q, mismatch_q, round_ok_q, full_q;

  logic [LW-1:0]    idx_inc_d;
  logic             idx_last_d, press_eq_d, wr_en_d;

  assign idx_inc_d  = idx_q + ONE;
  assign idx_last_d = (idx_q == len_q - ONE);
  assign press_eq_d = (press_sym_i == mem_q[idx_q[AW-1:0]]);
  assign wr_en_d    = reset && (state_q == IDLE) && !clear_i && append_i && !full_q;

  // Memory is not reset; only entries below len_q are ever read.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[len_q[AW-1:0]] <= rnd_i;
  end

`ifdef SIMON_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tmr_q;
  logic          timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      full_q       <= 1'b0;
      play_sym_q   <= '0;
      play_valid_q <= 1'b0;
      play_done_q  <= 1'b0;
      match_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      round_ok_q   <= 1'b0;
`ifdef SIMON_SEQ_TIMEOUT_EN
      tmr_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      play_done_q <= 1'b0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      round_ok_q  <= 1'b0;
`ifdef SIMON_SEQ_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            len_q  <= '0;
            full_q <= 1'b0;
          end else if (append_i) begin
            if (!full_q) begin
              len_q  <= len_q + ONE;
              full_q <= (len_q + ONE == MAX_L);
            end
          end else if (play_start_i) begin
            idx_q <= '0;
            if (len_q == '0) begin
              state_q     <= DONE;
              play_done_q <= 1'b1;
            end else begin
              state_q      <= PLAY;
              play_valid_q <= 1'b1;
              play_sym_q   <= mem_q[0];
            end
          end else if (chk_start_i) begin
            idx_q <= '0;
            if (len_q == '0) begin
              round_ok_q <= 1'b1;
            end else begin
              state_q <= CHECK;
`ifdef SIMON_SEQ_TIMEOUT_EN
              tmr_q   <= TO_LOAD;
`endif
            end
          end
        end
        PLAY: begin
          if (play_ready_i) begin
            if (idx_last_d) begin
              state_q      <= DONE;
              play_valid_q <= 1'b0;
              play_done_q  <= 1'b1;
            end else begin
              idx_q      <= idx_inc_d;
              play_sym_q <= mem_q[idx_inc_d[AW-1:0]];
            end
          end
        end
        DONE: state_q <= IDLE;
        CHECK: begin
          if (press_i) begin
`ifdef SIMON_SEQ_TIMEOUT_EN
            tmr_q <= TO_LOAD;
`endif
            if (press_eq_d) begin
              match_q <= 1'b1;
              if (idx_last_d) begin
                round_ok_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                idx_q <= idx_inc_d;
              end
            end else begin
              mismatch_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
`ifdef SIMON_SEQ_TIMEOUT_EN
          else if (tmr_q == '0) begin
            mismatch_q <= 1'b1;
            timeout_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign play_sym_o   = play_sym_q;
  assign play_valid_o = play_valid_q;
  assign play_done_o  = play_done_q;
  assign match_o      = match_q;
  assign mismatch_o   = mismatch_q;
  assign round_ok_o   = round_ok_q;
  assign len_o        = len_q;
  assign full_o       = full_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_simon_seq_player.sv
// Randomized scoreboard bench for simon_seq_player (MAX_LEN=4); timeout scenario with SIMON_SEQ_TIMEOUT_EN.
module tb_simon_seq_player;
  localparam int ML = 4;
`ifdef SIMON_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1000;
`endif
  localparam logic [4:0] EV_DONE = 5'b10000, EV_MATCH = 5'b01000, EV_MIS = 5'b00100,
                         EV_OK = 5'b00010, EV_TO = 5'b00001;

  logic clk = 0, rst_n = 0;
  logic [1:0] rnd_i = 0, press_sym_i = 0, play_sym_o;
  logic append_i = 0, clear_i = 0, play_start_i = 0, play_ready_i = 0;
  logic chk_start_i = 0, press_i = 0;
  logic play_valid_o, play_done_o, match_o, mismatch_o, round_ok_o, full_o, busy_o, timeout_o;
  logic [2:0] len_o;

  simon_seq_player #(.MAX_LEN(ML), .SYM_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(rst_n), .rnd_i(rnd_i), .append_i(append_i), .clear_i(clear_i),
    .play_start_i(play_start_i), .play_sym_o(play_sym_o), .play_valid_o(play_valid_o),
    .play_ready_i(play_ready_i), .play_done_o(play_done_o), .chk_start_i(chk_start_i),
    .press_i(press_i), .press_sym_i(press_sym_i), .match_o(match_o), .mismatch_o(mismatch_o),
    .round_ok_o(round_ok_o), .len_o(len_o), .full_o(full_o), .busy_o(busy_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int seq[$];          // reference model: stored colours
  int sym_q[$];        // expected playback symbols
  logic [4:0] ev_q[$]; // expected pulse sets

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or pulse.
  logic       hold_chk = 0;
  logic [1:0] held_sym = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 0;
    end else begin
      logic [4:0] ev;
      int s;
      ev = {play_done_o, match_o, mismatch_o, round_ok_o, timeout_o};
      if (play_valid_o && hold_chk) chk("play_hold", play_sym_o, held_sym);
      if (play_valid_o && play_ready_i) begin
        chk("play_sym_expected", int'(sym_q.size() > 0), 1);
        if (sym_q.size() > 0) begin
          s = sym_q.pop_front();
          chk("play_sym", play_sym_o, s);
        end
      end
      if (ev != 5'b0) begin
        chk("pulse_expected", int'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) chk("pulse_set", ev, ev_q.pop_front());
      end
      hold_chk = play_valid_o && !play_ready_i;
      held_sym = play_sym_o;
    end
  end

  task automatic do_append(int s, bit with_clear);
    rnd_i = s[1:0]; append_i = 1; clear_i = with_clear;
    if (with_clear) seq.delete();
    else if (seq.size() < ML) seq.push_back(s);
    cyc();
    append_i = 0; clear_i = 0;
    chk("len", len_o, seq.size());
    chk("full", full_o, int'(seq.size() == ML));
  endtask

  // mode: 0 random ready (with ignored appends), 1 always ready, 2 toggling ready
  task automatic do_play(int mode);
    int n = 0;
    foreach (seq[i]) sym_q.push_back(seq[i]);
    ev_q.push_back(EV_DONE);
    play_start_i = 1; cyc(); play_start_i = 0;
    do begin
      case (mode)
        0: begin
          play_ready_i = 1'($urandom_range(0, 1));
          append_i = 1'($urandom_range(0, 1)); rnd_i = 2'($urandom);
        end
        1: play_ready_i = 1;
        default: play_ready_i = (n % 2 == 0);
      endcase
      cyc(); n++;
    end while (busy_o && n < 200);
    play_ready_i = 0; append_i = 0;
    chk("play_finished", busy_o, 0);
    if (mode == 1) chk("play_cycles", n, seq.size() + 1);
    chk("len_after_play", len_o, seq.size());
  endtask

  // n correct presses, then optionally one wrong press (wsym<0: random wrong colour)
  task automatic do_check(int n, bit wrong, int wsym);
    int s;
    if (seq.size() == 0) ev_q.push_back(EV_OK);
    else begin
      for (int i = 0; i < n; i++) ev_q.push_back(i == seq.size() - 1 ? (EV_MATCH | EV_OK) : EV_MATCH);
      if (wrong) ev_q.push_back(EV_MIS);
    end
    chk_start_i = 1; cyc(); chk_start_i = 0;
    if (seq.size() > 0) begin
      for (int i = 0; i < n + int'(wrong); i++) begin
        repeat ($urandom_range(0, 3)) cyc();
        if (i < n) s = seq[i];
        else if (wsym >= 0) s = wsym;
        else s = (seq[i] + 1 + $urandom_range(0, 2)) % 4;
        press_i = 1; press_sym_i = s[1:0];
        cyc();
        press_i = 0;
      end
    end
    chk("check_busy_end", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    chk("rst_len", len_o, 0); chk("rst_full", full_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_pulses", {play_valid_o, play_done_o, match_o, mismatch_o, round_ok_o, timeout_o}, 0);
    rst_n = 1; cyc();

    do_append(2, 0); do_append(0, 0); do_append(3, 0); do_append(1, 0);
    do_play(1);
    do_play(2);
    do_check(4, 0, -1);
    do_check(1, 1, 1);
    do_append(2, 0);  // full: not stored
    do_play(1);
    do_append(3, 1);  // clear wins over append
    do_play(1);
    do_check(0, 0, -1);
    repeat (3) begin press_i = 1; press_sym_i = 2'($urandom); cyc(); press_i = 0; end

`ifdef SIMON_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      do_append(1, 0); do_append(3, 0);
      ev_q.push_back(EV_MIS | EV_TO);
      chk_start_i = 1; cyc(); chk_start_i = 0;
      do begin cyc(); n++; end while (busy_o && n < 50);
      chk("timeout_latency_ok", int'(n >= TO && n <= TO + 2), 1);
    end
`endif

    // Reset in the middle of playback drops everything without pulses.
    do_append(1, 0); do_append(2, 0);
    play_start_i = 1; cyc(); play_start_i = 0;
    chk("midplay_valid", play_valid_o, 1);
    play_ready_i = 0; rst_n = 0;
    sym_q.delete(); ev_q.delete(); seq.delete();
    cyc();
    rst_n = 1;
    chk("midrst_busy", busy_o, 0); chk("midrst_len", len_o, 0); chk("midrst_valid", play_valid_o, 0);
    repeat (3) cyc();

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) do_append($urandom_range(0, 3), 0);
      else if (op == 4) do_append($urandom_range(0, 3), $urandom_range(0, 3) == 0);
      else if (op <= 6) do_play($urandom_range(0, 2));
      else if (op <= 8) begin
        if (seq.size() > 0 && $urandom_range(0, 1) == 1) do_check($urandom_range(0, seq.size() - 1), 1, -1);
        else do_check(seq.size(), 0, -1);
      end else begin
        press_i = 1; press_sym_i = 2'($urandom); cyc(); press_i = 0;
      end
    end

    repeat (3) cyc();
    chk("sym_q_drained", sym_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
